// File: rtl/harmonic_sequencer_pkg.sv
// Shared definitions for the additive-synthesis harmonic sequencer:
// FSM state encoding, DAC framing constants and the sample scaling helper.
package harmonic_sequencer_pkg;

    typedef enum logic [2:0] {
        S_CLEAR,
        S_READ,
        S_CALC,
        S_WRITE,
        S_LUT,
        S_ACC,
        S_DRAIN,
        S_HOLD
    } state_t;

    localparam logic [7:0]  DAC_CMD   = 8'h31;
    localparam int unsigned LUT_SHIFT = 5;
    localparam logic [16:0] NYQUIST   = 17'h08000;

    // Bias the signed accumulator, divide by 4 and saturate to an unsigned 16-bit DAC code.
    function automatic logic [15:0] dac_scale(input logic [31:0] total, input logic [31:0] offset);
        logic signed [32:0] biased;
        logic signed [32:0] shifted;
        biased  = $signed({total[31], total}) + $signed({1'b0, offset});
        shifted = biased >>> 2;
        if (shifted < 0)
            return '0;
        else if (shifted > 33'sd65535)
            return '1;
        else
            return shifted[15:0];
    endfunction

endpackage

// File: rtl/harmonic_sequencer_if.sv
// Bundle of the sequencer's control inputs, RAM/LUT/adder side and DAC side.
interface harmonic_sequencer_if #(
    parameter int unsigned DIV_BIT = 7
);
    logic [15:0]        frequency;
    logic [7:0]         harmonic_count;
    logic [DIV_BIT-1:0] decay;
    logic [7:0]         sp_addr;
    logic [15:0]        sp_wdata;
    logic               sp_we;
    logic [15:0]        sp_rdata;
    logic [10:0]        lut_addr;
    logic               adder_start;
    logic               adder_clear;
    logic [DIV_BIT-1:0] adder_mult;
    logic               adder_ready;
    logic [31:0]        adder_total;
    logic [23:0]        dac_data;
    logic               dac_send;
    logic               busy;
    logic               overrun;

    modport master (
        input  frequency, harmonic_count, decay, sp_rdata, adder_ready, adder_total,
        output sp_addr, sp_wdata, sp_we, lut_addr, adder_start, adder_clear, adder_mult,
               dac_data, dac_send, busy, overrun
    );

    modport slave (
        output frequency, harmonic_count, decay, sp_rdata, adder_ready, adder_total,
        input  sp_addr, sp_wdata, sp_we, lut_addr, adder_start, adder_clear, adder_mult,
               dac_data, dac_send, busy, overrun
    );
endinterface

// File: rtl/sample_tick_gen.sv
// Free-running sample timer: tick is high for the last count of every INTERVAL-cycle period.
module sample_tick_gen #(
    parameter int unsigned INTERVAL = 1500
) (
    input  logic clock,
    input  logic reset,
    output logic o_tick
);
    localparam int unsigned W    = (INTERVAL > 2) ? $clog2(INTERVAL) : 1;
    localparam logic [W-1:0] LAST = W'(INTERVAL - 1);

    logic [W-1:0] r_count;

    always_ff @(posedge clock) begin
        if (reset || r_count == LAST)
            r_count <= '0;
        else
            r_count <= r_count + W'(1);
    end

    assign o_tick = (r_count == LAST);
endmodule

// File: rtl/harmonic_sequencer.sv
// Per-sample harmonic sequencer: walks the harmonics through phase RAM, sine LUT and
// scaled accumulator, then hands the formatted total to the DAC on each sample tick.
module harmonic_sequencer
    import harmonic_sequencer_pkg::*;
#(
    parameter int unsigned SAMPLE_INTERVAL = 1500,
    parameter int unsigned DIV_BIT         = 7,
    parameter logic [31:0] DAC_OFFSET      = 32'h20000,
    parameter logic [7:0]  DAC_CMD         = harmonic_sequencer_pkg::DAC_CMD
) (
    input  logic                 clock,
    input  logic                 reset,
    harmonic_sequencer_if.master bus
);
    state_t             r_state;
    logic [15:0]        r_freq;
    logic [7:0]         r_count;
    logic [DIV_BIT-1:0] r_decay;
    logic [DIV_BIT-1:0] r_mult;
    logic [16:0]        r_inc;
    logic [7:0]         r_h;
    logic [15:0]        r_pos;
    logic [15:0]        r_sample;
    logic               r_lut_wait;
    logic               r_drain_wait;
    logic [7:0]         r_sp_addr;
    logic [15:0]        r_sp_wdata;
    logic               r_sp_we;
    logic [10:0]        r_lut_addr;
    logic               r_adder_start;
    logic               r_adder_clear;
    logic [DIV_BIT-1:0] r_adder_mult;
    logic [23:0]        r_dac_data;
    logic               r_dac_send;
    logic               r_busy;
    logic               r_overrun;

    logic               w_tick;
    logic [7:0]         w_h_next;
    logic [16:0]        w_inc_next;
    logic               w_exhausted;
    logic               w_done;

    sample_tick_gen #(.INTERVAL(SAMPLE_INTERVAL)) u_tick (
        .clock  (clock),
        .reset  (reset),
        .o_tick (w_tick)
    );

    assign w_h_next    = r_h + 8'd1;
    assign w_inc_next  = r_inc + {1'b0, r_freq};
    assign w_exhausted = (r_mult <= r_decay);
    assign w_done      = (w_h_next == r_count) || (w_inc_next >= NYQUIST) || w_exhausted;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_CLEAR;
            r_freq        <= '0;
            r_count       <= '0;
            r_decay       <= '0;
            r_mult        <= '0;
            r_inc         <= '0;
            r_h           <= '0;
            r_pos         <= '0;
            r_sample      <= '0;
            r_lut_wait    <= 1'b0;
            r_drain_wait  <= 1'b0;
            r_sp_addr     <= '0;
            r_sp_wdata    <= '0;
            r_sp_we       <= 1'b0;
            r_lut_addr    <= '0;
            r_adder_start <= 1'b0;
            r_adder_clear <= 1'b0;
            r_adder_mult  <= '0;
            r_dac_data    <= {DAC_CMD, 16'h8000};
            r_dac_send    <= 1'b0;
            r_busy        <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_sp_we       <= 1'b0;
            r_adder_start <= 1'b0;
            r_adder_clear <= 1'b0;
            r_overrun     <= 1'b0;
            // The DAC is fed on every tick; a late frame just repeats the last sample.
            r_dac_send    <= w_tick;
            if (w_tick && r_state != S_HOLD)
                r_overrun <= 1'b1;

            case (r_state)
                S_CLEAR: begin
                    r_adder_clear <= 1'b1;
                    r_busy        <= 1'b1;
                    r_freq        <= bus.frequency;
                    r_count       <= bus.harmonic_count;
                    r_decay       <= bus.decay;
                    r_inc         <= {1'b0, bus.frequency};
                    r_h           <= '0;
                    r_mult        <= '1;
                    r_sp_addr     <= '0;
                    r_drain_wait  <= 1'b1;
                    if (bus.harmonic_count == 8'd0 || {1'b0, bus.frequency} >= NYQUIST)
                        r_state <= S_DRAIN;
                    else
                        r_state <= S_READ;
                end
                S_READ: r_state <= S_CALC;
                S_CALC: begin
                    r_pos   <= bus.sp_rdata + r_inc[15:0];
                    r_state <= S_WRITE;
                end
                S_WRITE: begin
                    r_sp_we    <= 1'b1;
                    r_sp_wdata <= r_pos;
                    r_lut_addr <= r_pos[15:LUT_SHIFT];
                    r_lut_wait <= 1'b0;
                    r_state    <= S_LUT;
                end
                S_LUT: begin
                    r_lut_wait <= 1'b1;
                    if (r_lut_wait)
                        r_state <= S_ACC;
                end
                S_ACC: begin
                    if (bus.adder_ready) begin
                        r_adder_start <= 1'b1;
                        r_adder_mult  <= r_mult;
                        r_h           <= w_h_next;
                        r_inc         <= w_inc_next;
                        r_sp_addr     <= w_h_next;
                        if (!w_exhausted)
                            r_mult <= r_mult - r_decay;
                        r_drain_wait  <= 1'b1;
                        r_state       <= w_done ? S_DRAIN : S_READ;
                    end
                end
                S_DRAIN: begin
                    r_drain_wait <= 1'b0;
                    if (!r_drain_wait && bus.adder_ready) begin
                        r_sample <= dac_scale(bus.adder_total, DAC_OFFSET);
                        r_busy   <= 1'b0;
                        r_state  <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (w_tick) begin
                        r_dac_data <= {DAC_CMD, r_sample};
                        r_busy     <= 1'b1;
                        r_state    <= S_CLEAR;
                    end
                end
                default: r_state <= S_CLEAR;
            endcase
        end
    end

    assign bus.sp_addr     = r_sp_addr;
    assign bus.sp_wdata    = r_sp_wdata;
    assign bus.sp_we       = r_sp_we;
    assign bus.lut_addr    = r_lut_addr;
    assign bus.adder_start = r_adder_start;
    assign bus.adder_clear = r_adder_clear;
    assign bus.adder_mult  = r_adder_mult;
    assign bus.dac_data    = r_dac_data;
    assign bus.dac_send    = r_dac_send;
    assign bus.busy        = r_busy;
    assign bus.overrun     = r_overrun;
endmodule

// File: tb/tb_harmonic_sequencer.sv
// Scoreboard bench for harmonic_sequencer with RAM, LUT and accumulator models.
`timescale 1ns/1ps
module tb_harmonic_sequencer;

    typedef struct {
        int          cyc;
        logic [7:0]  addr;
        logic [15:0] data;
        logic [10:0] lut;
    } wr_t;

    typedef struct {
        int          cyc;
        logic [23:0] data;
    } dac_t;

    logic clock  = 1'b0;
    logic reset  = 1'b1;
    logic reset2 = 1'b1;
    always #5 clock = ~clock;

    harmonic_sequencer_if #(.DIV_BIT(7)) bus ();
    harmonic_sequencer_if #(.DIV_BIT(7)) bus2 ();

    harmonic_sequencer #(.SAMPLE_INTERVAL(1500), .DIV_BIT(7)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    harmonic_sequencer #(.SAMPLE_INTERVAL(20), .DIV_BIT(7)) dut20 (
        .clock (clock),
        .reset (reset2),
        .bus   (bus2)
    );

    // Phase RAM model, registered read.
    logic [15:0] mem [256];
    logic        ram_zero = 1'b0;
    always @(posedge clock) begin
        if (ram_zero) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (bus.sp_we) begin
            mem[bus.sp_addr] <= bus.sp_wdata;
        end
        bus.sp_rdata <= mem[bus.sp_addr];
    end

    // Sine LUT model with 2-cycle latency.
    logic [10:0] lut_d1, lut_q;
    always @(posedge clock) begin
        lut_d1 <= bus.lut_addr;
        lut_q  <= lut_d1;
    end

    // Accumulator model.
    logic signed [31:0] acc;
    int                 busy_cnt;
    logic               hold_ready = 1'b0;
    logic               use_ovr    = 1'b0;
    logic [31:0]        ovr        = '0;
    always @(posedge clock) begin
        if (reset) begin
            acc      <= '0;
            busy_cnt <= 0;
        end else if (bus.adder_clear) begin
            acc <= '0;
        end else if (bus.adder_start) begin
            acc      <= acc + (int'(lut_q) - 1024) * int'(bus.adder_mult);
            busy_cnt <= 3;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end
    assign bus.adder_ready = !hold_ready && busy_cnt == 0 && !bus.adder_start;
    assign bus.adder_total = use_ovr ? ovr : acc;

    // Second instance: zero RAM, always-ready adder, constant total.
    assign bus2.sp_rdata    = 16'h0000;
    assign bus2.adder_ready = 1'b1;
    assign bus2.adder_total = 32'd4;

    int cyc, cyc2;
    always @(posedge clock) cyc  <= reset  ? 0 : cyc + 1;
    always @(posedge clock) cyc2 <= reset2 ? 0 : cyc2 + 1;

    // Observation logs; comparisons happen in the test tasks.
    wr_t        obs_wr[$];
    logic [6:0] obs_mult[$];
    dac_t       obs_dac[$];
    dac_t       obs_dac2[$];
    int         obs_ovr2[$];
    int         n_clr = 0;
    always @(negedge clock) begin
        if (!reset) begin
            if (bus.sp_we) obs_wr.push_back('{cyc, bus.sp_addr, bus.sp_wdata, bus.lut_addr});
            if (bus.adder_start) obs_mult.push_back(bus.adder_mult);
            if (bus.adder_clear) n_clr++;
            if (bus.dac_send) obs_dac.push_back('{cyc, bus.dac_data});
        end
        if (!reset2) begin
            if (bus2.dac_send) obs_dac2.push_back('{cyc2, bus2.dac_data});
            if (bus2.overrun) obs_ovr2.push_back(cyc2);
        end
    end

    wr_t        exp_wr[$];
    logic [6:0] exp_mult[$];
    dac_t       exp_dac[$];
    int         exp_ovr[$];
    int         errors = 0;
    int         checks = 0;
    int         b_wr, b_mult, b_dac, b_clr;

    task automatic run(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic start_run(input logic [15:0] f, input logic [7:0] n, input logic [6:0] d);
        @(negedge clock);
        reset              = 1'b1;
        bus.frequency      = f;
        bus.harmonic_count = n;
        bus.decay          = d;
        ram_zero           = 1'b1;
        @(negedge clock);
        ram_zero = 1'b0;
        @(negedge clock);
        b_wr   = obs_wr.size();
        b_mult = obs_mult.size();
        b_dac  = obs_dac.size();
        b_clr  = n_clr;
        reset  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        run(3);
        checks++;
        if ({bus.sp_addr, bus.sp_wdata, bus.sp_we, bus.lut_addr, bus.adder_start, bus.adder_clear,
             bus.adder_mult, bus.dac_send, bus.busy, bus.overrun} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got addr=%h wdata=%h we=%b lut=%h start=%b clr=%b mult=%h send=%b busy=%b ovr=%b, required all zero",
                     bus.sp_addr, bus.sp_wdata, bus.sp_we, bus.lut_addr, bus.adder_start, bus.adder_clear,
                     bus.adder_mult, bus.dac_send, bus.busy, bus.overrun);
        end
        checks++;
        if (bus.dac_data !== 24'h318000) begin
            errors++;
            $display("FAIL reset_dac_data: got %h required 318000", bus.dac_data);
        end
    endtask

    task automatic test_silence();
        dac_t e, o;
        int   idx;
        start_run(16'd0, 8'd0, 7'd0);
        for (int k = 1; k <= 3; k++) begin
            e.cyc  = k * 1500;
            e.data = 24'h318000;
            exp_dac.push_back(e);
        end
        run(4502);
        checks++;
        if (obs_wr.size() - b_wr !== 0 || obs_mult.size() - b_mult !== 0) begin
            errors++;
            $display("FAIL silence_activity: got %0d writes %0d starts, required 0 and 0",
                     obs_wr.size() - b_wr, obs_mult.size() - b_mult);
        end
        checks++;
        if (obs_dac.size() - b_dac !== 3) begin
            errors++;
            $display("FAIL silence_send_count: got %0d required 3", obs_dac.size() - b_dac);
        end
        idx = b_dac;
        while (exp_dac.size() > 0) begin
            e = exp_dac.pop_front();
            checks++;
            if (idx >= obs_dac.size()) begin
                errors++;
                $display("FAIL silence_send: got no send, required cycle %0d data %h", e.cyc, e.data);
            end else begin
                o = obs_dac[idx];
                if (o.cyc !== e.cyc || o.data !== e.data) begin
                    errors++;
                    $display("FAIL silence_send: got cycle %0d data %h, required cycle %0d data %h",
                             o.cyc, o.data, e.cyc, e.data);
                end
            end
            idx++;
        end
    endtask

    task automatic test_single();
        wr_t e, o;
        int  idx;
        start_run(16'd1000, 8'd1, 7'd0);
        e = '{0, 8'd0, 16'd1000, 11'd31};
        exp_wr.push_back(e);
        e = '{0, 8'd0, 16'd2000, 11'd62};
        exp_wr.push_back(e);
        run(3002);
        checks++;
        if (obs_wr.size() - b_wr !== 2) begin
            errors++;
            $display("FAIL single_write_count: got %0d required 2", obs_wr.size() - b_wr);
        end
        idx = b_wr;
        while (exp_wr.size() > 0) begin
            e = exp_wr.pop_front();
            checks++;
            if (idx >= obs_wr.size()) begin
                errors++;
                $display("FAIL single_write: got no write, required addr %0d data %0d", e.addr, e.data);
            end else begin
                o = obs_wr[idx];
                if (o.addr !== e.addr || o.data !== e.data || o.lut !== e.lut) begin
                    errors++;
                    $display("FAIL single_write: got addr %0d data %0d lut %0d, required addr %0d data %0d lut %0d",
                             o.addr, o.data, o.lut, e.addr, e.data, e.lut);
                end
            end
            idx++;
        end
    endtask

    task automatic test_harmonics();
        wr_t        e, o;
        logic [6:0] em;
        int         idx;
        start_run(16'd1000, 8'd3, 7'd10);
        for (int k = 0; k < 3; k++) begin
            e.cyc  = 0;
            e.addr = 8'(k);
            e.data = 16'((k + 1) * 1000);
            e.lut  = 11'(((k + 1) * 1000) / 32);
            exp_wr.push_back(e);
            exp_mult.push_back(7'(127 - 10 * k));
        end
        run(1400);
        checks++;
        if (n_clr - b_clr !== 1 || obs_mult.size() - b_mult !== 3) begin
            errors++;
            $display("FAIL harm_pulse_count: got %0d clears %0d starts, required 1 and 3",
                     n_clr - b_clr, obs_mult.size() - b_mult);
        end
        idx = b_wr;
        while (exp_wr.size() > 0) begin
            e = exp_wr.pop_front();
            checks++;
            if (idx >= obs_wr.size()) begin
                errors++;
                $display("FAIL harm_write: got no write, required addr %0d data %0d", e.addr, e.data);
            end else begin
                o = obs_wr[idx];
                if (o.addr !== e.addr || o.data !== e.data || o.lut !== e.lut) begin
                    errors++;
                    $display("FAIL harm_write: got addr %0d data %0d lut %0d, required addr %0d data %0d lut %0d",
                             o.addr, o.data, o.lut, e.addr, e.data, e.lut);
                end
            end
            idx++;
        end
        idx = b_mult;
        while (exp_mult.size() > 0) begin
            em = exp_mult.pop_front();
            checks++;
            if (idx >= obs_mult.size() || obs_mult[idx] !== em) begin
                errors++;
                $display("FAIL harm_mult: got %0d required %0d",
                         (idx < obs_mult.size()) ? int'(obs_mult[idx]) : -1, em);
            end
            idx++;
        end
    endtask

    task automatic test_nyquist();
        wr_t e, o;
        int  idx;
        start_run(16'd12000, 8'd8, 7'd0);
        e = '{0, 8'd0, 16'd12000, 11'd375};
        exp_wr.push_back(e);
        e = '{0, 8'd1, 16'd24000, 11'd750};
        exp_wr.push_back(e);
        run(1400);
        checks++;
        if (obs_mult.size() - b_mult !== 2) begin
            errors++;
            $display("FAIL nyq_start_count: got %0d required 2", obs_mult.size() - b_mult);
        end
        checks++;
        if (obs_wr.size() - b_wr !== 2) begin
            errors++;
            $display("FAIL nyq_write_count: got %0d required 2", obs_wr.size() - b_wr);
        end
        idx = b_wr;
        while (exp_wr.size() > 0) begin
            e = exp_wr.pop_front();
            checks++;
            if (idx >= obs_wr.size()) begin
                errors++;
                $display("FAIL nyq_write: got no write, required addr %0d data %0d", e.addr, e.data);
            end else begin
                o = obs_wr[idx];
                if (o.addr !== e.addr || o.data !== e.data || o.lut !== e.lut) begin
                    errors++;
                    $display("FAIL nyq_write: got addr %0d data %0d lut %0d, required addr %0d data %0d lut %0d",
                             o.addr, o.data, o.lut, e.addr, e.data, e.lut);
                end
            end
            idx++;
        end
    endtask

    task automatic test_clamp();
        dac_t e, o;
        int   idx;
        use_ovr = 1'b1;
        ovr     = 32'h7FFF_FFF0;
        start_run(16'd0, 8'd0, 7'd0);
        e = '{1500, 24'h31FFFF};
        exp_dac.push_back(e);
        e = '{3000, 24'h310000};
        exp_dac.push_back(e);
        run(100);
        ovr = 32'hFFF0_0000;
        run(2902);
        use_ovr = 1'b0;
        idx = b_dac;
        while (exp_dac.size() > 0) begin
            e = exp_dac.pop_front();
            checks++;
            if (idx >= obs_dac.size()) begin
                errors++;
                $display("FAIL clamp_send: got no send, required cycle %0d data %h", e.cyc, e.data);
            end else begin
                o = obs_dac[idx];
                if (o.cyc !== e.cyc || o.data !== e.data) begin
                    errors++;
                    $display("FAIL clamp_send: got cycle %0d data %h, required cycle %0d data %h",
                             o.cyc, o.data, e.cyc, e.data);
                end
            end
            idx++;
        end
    endtask

    task automatic test_overrun();
        dac_t e, o;
        int   idx, eo, bd, bo;
        bus2.frequency      = 16'd1000;
        bus2.harmonic_count = 8'd8;
        bus2.decay          = 7'd0;
        run(2);
        bd     = obs_dac2.size();
        bo     = obs_ovr2.size();
        reset2 = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            e.cyc  = 20 * k;
            e.data = (k <= 2) ? 24'h318000 : 24'h318001;
            exp_dac.push_back(e);
        end
        exp_ovr.push_back(20);
        exp_ovr.push_back(40);
        exp_ovr.push_back(80);
        exp_ovr.push_back(100);
        run(122);
        checks++;
        if (obs_dac2.size() - bd !== 6 || obs_ovr2.size() - bo !== 4) begin
            errors++;
            $display("FAIL ovr_counts: got %0d sends %0d overruns, required 6 and 4",
                     obs_dac2.size() - bd, obs_ovr2.size() - bo);
        end
        idx = bd;
        while (exp_dac.size() > 0) begin
            e = exp_dac.pop_front();
            checks++;
            if (idx >= obs_dac2.size()) begin
                errors++;
                $display("FAIL ovr_send: got no send, required cycle %0d data %h", e.cyc, e.data);
            end else begin
                o = obs_dac2[idx];
                if (o.cyc !== e.cyc || o.data !== e.data) begin
                    errors++;
                    $display("FAIL ovr_send: got cycle %0d data %h, required cycle %0d data %h",
                             o.cyc, o.data, e.cyc, e.data);
                end
            end
            idx++;
        end
        idx = bo;
        while (exp_ovr.size() > 0) begin
            eo = exp_ovr.pop_front();
            checks++;
            if (idx >= obs_ovr2.size() || obs_ovr2[idx] !== eo) begin
                errors++;
                $display("FAIL ovr_pulse: got cycle %0d required cycle %0d",
                         (idx < obs_ovr2.size()) ? obs_ovr2[idx] : -1, eo);
            end
            idx++;
        end
        reset2 = 1'b1;
    endtask

    task automatic test_reset_mid_acc();
        hold_ready = 1'b1;
        start_run(16'd1000, 8'd1, 7'd0);
        run(20);
        checks++;
        if (obs_mult.size() - b_mult !== 0 || bus.busy !== 1'b1 || bus.lut_addr !== 11'd31) begin
            errors++;
            $display("FAIL stall_acc: got starts %0d busy %b lut %0d, required 0, 1, 31",
                     obs_mult.size() - b_mult, bus.busy, bus.lut_addr);
        end
        reset = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if ({bus.sp_addr, bus.sp_wdata, bus.sp_we, bus.lut_addr, bus.adder_start, bus.adder_clear,
             bus.adder_mult, bus.dac_send, bus.busy, bus.overrun} !== '0 || bus.dac_data !== 24'h318000) begin
            errors++;
            $display("FAIL mid_reset: got wdata=%h lut=%h busy=%b dac=%h, required 0 0 0 318000",
                     bus.sp_wdata, bus.lut_addr, bus.busy, bus.dac_data);
        end
        checks++;
        if (mem[0] !== 16'd1000) begin
            errors++;
            $display("FAIL mid_reset_ram: got %0d required 1000", mem[0]);
        end
        hold_ready = 1'b0;
    endtask

    initial begin
        bus.frequency       = '0;
        bus.harmonic_count  = '0;
        bus.decay           = '0;
        bus2.frequency      = '0;
        bus2.harmonic_count = '0;
        bus2.decay          = '0;
        test_reset();
        test_silence();
        test_single();
        test_harmonics();
        test_nyquist();
        test_clamp();
        test_overrun();
        test_reset_mid_acc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/harmonic_sequencer.md
Name: harmonic_sequencer

Overview:
Per-sample controller for the additive-synthesis datapath. Once per sample frame it steps through the harmonics. For each harmonic it reads and updates that harmonic's phase in the sample-position RAM, addresses the sine LUT, and issues a scaled accumulate to the Fraction adder. It then formats the accumulated total and hands it to DAC_SPI_Out on a fixed sample tick. It replaces the inline sequencing in top and adds a harmonic-count limit, a Nyquist cutoff and overrun detection.

Parameters:
SAMPLE_INTERVAL, 1500, clocks per output sample (72 MHz / 48 kHz)
DIV_BIT, 7, width of the adder_mult fraction
DAC_OFFSET, 32'h20000, bias added to adder_total before scaling
DAC_CMD, 8'h31, DAC command byte (write channel A)

Ports:
clock  in  1  system clock (72 MHz PLL)
reset  in  1  synchronous, active-high
frequency  in  16  fundamental phase increment per sample (65536 = one cycle)
harmonic_count  in  8  harmonics to synthesise; 0 = silence
decay  in  DIV_BIT  amplitude decrement per harmonic
sp_addr  out  8  sample-position RAM address (harmonic index)
sp_wdata  out  16  new phase to write
sp_we  out  1  RAM write enable
sp_rdata  in  16  RAM read data, 1-cycle registered latency
lut_addr  out  11  sine LUT address; LUT Q valid 2 cycles later
adder_start  out  1  1-cycle pulse: accumulate lut_value*adder_mult
adder_clear  out  1  1-cycle pulse: zero the accumulator
adder_mult  out  DIV_BIT  amplitude fraction for the current start
adder_ready  in  1  adder idle
adder_total  in  32  signed accumulated sum
dac_data  out  24  {DAC_CMD, sample}
dac_send  out  1  1-cycle pulse to DAC_SPI_Out
busy  out  1  high while a frame is being computed
overrun  out  1  1-cycle pulse when a tick occurs before the frame is done

Behaviour:
- Reset values:
  - All outputs 0, except dac_data = {DAC_CMD,16'h8000}.
  - State S_CLEAR; sample timer 0.
  - Reset mid-frame abandons the frame; RAM contents are untouched.
- Sample timer:
  - Counts 0..SAMPLE_INTERVAL-1, free-running and independent of the FSM.
  - tick is asserted when the timer equals SAMPLE_INTERVAL-1.
  - The first tick occurs SAMPLE_INTERVAL cycles after reset deasserts.
- S_CLEAR:
  - Pulse adder_clear.
  - Latch frequency, harmonic_count and decay.
  - Set the 17-bit inc = frequency, h = 0, adder_mult = 2^DIV_BIT-1.
  - If harmonic_count == 0 or frequency >= 16'h8000, go to S_DRAIN; otherwise go to S_READ.
- S_READ: sp_addr = h; wait 1 cycle.
- S_CALC: pos = sp_rdata + inc[15:0], 16-bit wrap.
- S_WRITE:
  - sp_we = 1 for exactly 1 cycle, sp_wdata = pos.
  - lut_addr = pos[15:5].
- S_LUT: wait 2 cycles for LUT latency.
- S_ACC:
  - Wait for adder_ready, then pulse adder_start with the current adder_mult.
  - Then update: h++, inc += frequency.
  - adder_mult = adder_mult - decay if adder_mult > decay; otherwise the frame terminates.
- Termination, checked after each S_ACC; any one condition goes to S_DRAIN, otherwise go to S_READ:
  - h == harmonic_count;
  - new inc >= 17'h08000 (Nyquist);
  - amplitude exhausted.
- Skipped harmonics keep stale phase; this is acceptable because they are silent.
- S_DRAIN:
  - Wait 1 cycle, then wait for adder_ready.
  - Compute s = (adder_total + DAC_OFFSET) >>> 2.
  - Clamp s to 0..65535 and register it.
  - Go to S_HOLD.
- S_HOLD: on tick, dac_data = {DAC_CMD, s}, dac_send = 1 for 1 cycle, then go to S_CLEAR.
- busy = 1 in every state except S_HOLD.
- Overrun (tick while not in S_HOLD):
  - overrun pulses for 1 cycle.
  - dac_send still pulses, re-sending the previous dac_data, so the sample rate never slips.
  - The FSM continues and sends its result on the next tick.
- A tick on the same cycle S_DRAIN reaches S_HOLD counts as an overrun; the result goes out on the following tick.
- adder_start and sp_we are never asserted in the same cycle as adder_clear.

Decomposition:
- Shared package holds:
  - state encodings S_CLEAR..S_HOLD;
  - DAC_CMD;
  - LUT_SHIFT = 5;
  - NYQUIST = 17'h08000.
- One sub-module, sample_tick_gen: parameterised counter producing tick.
- Everything else stays inline in harmonic_sequencer.

Test Plan:
1. Reset release, harmonic_count = 0 -> no sp_we or adder_start; dac_send exactly at cycle 1500 with dac_data = 24'h318000; repeats every 1500 cycles.
2. frequency = 1000, count = 1, RAM zeroed -> frame 1 writes addr 0 = 1000, lut_addr = 31; frame 2 writes 2000, lut_addr = 62.
3. frequency = 1000, count = 3, decay = 10 -> writes addr 0/1/2 = 1000/2000/3000; adder_mult sequence 127, 117, 107; 3 adder_start pulses and 1 adder_clear per frame.
4. frequency = 12000, count = 8 -> only 2 harmonics (24000 < 32768, 36000 stops); exactly 2 adder_start pulses.
5. Adder model with adder_total = 32'sh7FFFFFF0 -> s clamps to 16'hFFFF; adder_total = -32'sh100000 -> s = 16'h0000.
6. SAMPLE_INTERVAL = 20, count = 8 -> overrun pulses; dac_send still every 20 cycles with the previous data. Separately, reset asserted mid-S_ACC -> all outputs return to reset values next cycle.
